rd_desc_fifo: RTL and testbench
===============================

RD_DESC_FIFO -- requirements
Module: rd_desc_fifo

Interface
REQ-001 SHALL have parameter DW, default 8: descriptor width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: entry count; a power of two and at least 2.
REQ-003 SHALL have parameter AFULL_TH, default 6: almost-full threshold, in the range 1..DEPTH.
REQ-004 SHALL have port iClk, input, 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port iRst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port iReq, input, 1: upstream valid from the WRR arbiter output.
REQ-007 SHALL have port oGnt, output, 1: upstream ready.
REQ-008 SHALL have port iData, input, DW: upstream descriptor.
REQ-009 SHALL have port oReq, output, 1: downstream valid to the read engine.
REQ-010 SHALL have port iGnt, input, 1: downstream ready.
REQ-011 SHALL have port oData, output, DW: head descriptor.
REQ-012 SHALL have port iFlush, input, 1: synchronous discard of all entries.
REQ-013 SHALL have port oCount, output, $clog2(DEPTH)+1: current occupancy.
REQ-014 SHALL have port oAlmostFull, output, 1: high when occupancy is at least AFULL_TH.
REQ-015 SHALL have port oMaxCount, output, $clog2(DEPTH)+1: peak occupancy since reset or flush.

Function
REQ-016 SHALL push when iReq && oGnt at a rising edge; SHALL pop when oReq && iGnt at a rising edge.
REQ-017 SHALL drive oGnt = !full and oReq = !empty, both decoded from registered pointers only; no combinational path from iReq to oGnt or from iGnt to oReq.
REQ-018 SHALL be first-word-fall-through: oData = mem[rd_ptr], valid whenever oReq=1.
REQ-019 SHALL make a word pushed at edge N visible on oReq/oData after edge N; latency is 1 cycle and there is no bypass when empty.
REQ-020 SHALL use rd/wr pointers of $clog2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; empty = pointers equal; pointers wrap naturally from DEPTH-1 to 0.
REQ-021 SHALL, on a simultaneous push and pop (neither full nor empty), advance both pointers and leave oCount unchanged.
REQ-022 SHALL, when full, accept no push even if a pop occurs in the same cycle; oGnt rises the cycle after the pop.
REQ-023 SHALL, when empty, perform no pop; iGnt is ignored.
REQ-024 SHALL hold oData stable while oReq=1 and iGnt=0.
REQ-025 SHALL update oCount registered: +1 on push only, -1 on pop only.
REQ-026 SHALL register oAlmostFull, computed from the next-state count.
REQ-027 SHALL load oMaxCount with the next-state count whenever that count exceeds oMaxCount.
REQ-028 SHALL, when iFlush=1, override push and pop; at the next edge pointers, oCount, oAlmostFull and oMaxCount become 0 and memory contents are don't-care.
REQ-029 SHALL apply iFlush for a single cycle; oGnt remains !full during the flush cycle, but any push in that cycle is discarded.

Reset
REQ-030 SHALL, while iRst=1 at an edge, clear pointers, oCount, oAlmostFull and oMaxCount; after reset oReq=0 and oGnt=1.
REQ-031 SHALL give iRst priority over iFlush, push and pop, and SHALL drop all contents on a reset applied mid-transfer.
REQ-032 SHALL NOT reset the memory array.

Structure
REQ-033 SHALL need no shared package; width constants are localparams derived from DEPTH.
REQ-034 SHALL keep storage in one sub-module, sync_dpram (1 write port, 1 asynchronous read port, DW x DEPTH); the pointer, count and flag logic stays in rd_desc_fifo.
REQ-035 SHALL instantiate directly downstream of WrrArbiter: oReq to iReq, oData to iData, iGnt to oGnt.

Verification (DW=8, DEPTH=4, AFULL_TH=3)
REQ-036 SHALL cover fill: push 0x11,0x22,0x33,0x44 back-to-back with iGnt=0 -> oCount 1,2,3,4; oAlmostFull=1 after the 3rd push; oGnt=0 after the 4th; oData=0x11.
REQ-037 SHALL cover full-blocking: when full, hold iReq=1 with 0x55 and pulse iGnt for one cycle -> 0x11 popped, 0x55 not accepted that cycle, accepted the next cycle; output order 0x22,0x33,0x44,0x55.
REQ-038 SHALL cover streaming: iReq=iGnt=1 for 20 cycles with an incrementing pattern -> after the first cycle oCount stays 1, one word per cycle out, in order, no loss.
REQ-039 SHALL cover wrap-around: 10 fill/drain cycles of 3 words each -> pointers wrap, order preserved, oMaxCount=3.
REQ-040 SHALL cover flush: with 3 entries, assert iFlush together with iReq=1 (0x99) -> next cycle oReq=0, oCount=0, oMaxCount=0, and 0x99 is never output.
REQ-041 SHALL cover reset: assert iRst with 2 entries and iReq=iGnt=1 -> next cycle oReq=0, oGnt=1, oCount=0; a subsequent push of 0xA5 appears as oData 1 cycle later.

Source files
------------

// File: rtl/sync_dpram.sv
// rtl/sync_dpram.sv - descriptor storage with one write port and one asynchronous read port
//
// Purpose: DW x DEPTH storage array for rd_desc_fifo. Writes happen on the
// rising edge of iClk when iWe is high; the read port is combinational so the
// FIFO head is available in the same cycle its address is presented.
// The array has no reset; its contents are only meaningful between the
// FIFO's read and write pointers.
//
// Ports:
//   iClk     - clock, rising edge
//   iWe      - write enable
//   iWrAddr  - write address
//   iWrData  - write data
//   iRdAddr  - read address
//   oRdData  - read data, mem[iRdAddr]
module sync_dpram #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          iClk,
    input  logic          iWe,
    input  logic [AW-1:0] iWrAddr,
    input  logic [DW-1:0] iWrData,
    input  logic [AW-1:0] iRdAddr,
    output logic [DW-1:0] oRdData
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem[iWrAddr] <= iWrData;
        end
    end

    assign oRdData = mem[iRdAddr];

endmodule

// File: rtl/rd_desc_fifo.sv
// rtl/rd_desc_fifo.sv - first-word-fall-through read descriptor FIFO behind the WRR arbiter
//
// Purpose: buffers read descriptors between the WRR arbiter and the read
// engine. The head entry is presented on oData whenever oReq is high.
// oGnt and oReq decode only from registered pointers, so there is no
// combinational path from iReq to oGnt or from iGnt to oReq.
//
// Ports:
//   iClk        - clock, rising edge
//   iRst        - synchronous active-high reset; takes priority over everything
//   iReq/oGnt   - upstream valid/ready, iData is the upstream descriptor
//   oReq/iGnt   - downstream valid/ready, oData is the head descriptor
//   iFlush      - single-cycle synchronous discard of all entries
//   oCount      - registered occupancy
//   oAlmostFull - registered, high when occupancy >= AFULL_TH
//   oMaxCount   - peak occupancy since the last reset or flush
module rd_desc_fifo #(
    parameter int DW       = 8,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 6
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iReq,
    output logic                     oGnt,
    input  logic [DW-1:0]            iData,
    output logic                     oReq,
    input  logic                     iGnt,
    output logic [DW-1:0]            oData,
    input  logic                     iFlush,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oAlmostFull,
    output logic [$clog2(DEPTH):0]   oMaxCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_TH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] countNext;
    logic          full;
    logic          empty;
    logic          doPush;
    logic          doPop;

    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign empty = (wrPtr == rdPtr);

    assign oGnt = !full;
    assign oReq = !empty;

    // A flush cycle still shows oGnt = !full, but whatever is offered is dropped.
    assign doPush = iReq && !full && !iFlush;
    assign doPop  = iGnt && !empty && !iFlush;

    always_comb begin
        countNext = oCount;
        if (doPush && !doPop) begin
            countNext = oCount + 1'b1;
        end else if (!doPush && doPop) begin
            countNext = oCount - 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst || iFlush) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            oCount      <= '0;
            oAlmostFull <= 1'b0;
            oMaxCount   <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            oCount      <= countNext;
            oAlmostFull <= (countNext >= AFULL_LVL);
            if (countNext > oMaxCount) begin
                oMaxCount <= countNext;
            end
        end
    end

    // Writes are gated by reset too, so a descriptor offered during reset is not stored.
    sync_dpram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) uMem (
        .iClk    (iClk),
        .iWe     (doPush && !iRst),
        .iWrAddr (wrPtr[AW-1:0]),
        .iWrData (iData),
        .iRdAddr (rdPtr[AW-1:0]),
        .oRdData (oData)
    );

endmodule

// File: tb/tb_rd_desc_fifo.sv
// tb/tb_rd_desc_fifo.sv - self-checking bench for rd_desc_fifo with a scoreboard queue
module tb_rd_desc_fifo;

    localparam int DW       = 8;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;

    logic       iClk;
    logic       iRst;
    logic       iReq;
    logic       oGnt;
    logic [7:0] iData;
    logic       oReq;
    logic       iGnt;
    logic [7:0] oData;
    logic       iFlush;
    logic [2:0] oCount;
    logic       oAlmostFull;
    logic [2:0] oMaxCount;

    int         nChecks = 0;
    int         nFails  = 0;
    logic [7:0] sb[$];
    int         mMax = 0;
    logic       resetDone = 1'b0;

    rd_desc_fifo #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iReq        (iReq),
        .oGnt        (oGnt),
        .iData       (iData),
        .oReq        (oReq),
        .iGnt        (iGnt),
        .oData       (oData),
        .iFlush      (iFlush),
        .oCount      (oCount),
        .oAlmostFull (oAlmostFull),
        .oMaxCount   (oMaxCount)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic drive(input logic req, input logic [7:0] d, input logic gnt, input logic flush);
        iReq   = req;
        iData  = d;
        iGnt   = gnt;
        iFlush = flush;
    endtask

    // Scoreboard step: inputs are already driven; check handshake outputs
    // against the model, pop/compare on a pop, push on a push, then advance.
    task automatic step();
        logic       mPush;
        logic       mPop;
        logic [7:0] exp;
        #1;
        mPush = iReq && (sb.size() < DEPTH) && !iFlush && !iRst;
        mPop  = iGnt && (sb.size() != 0) && !iFlush && !iRst;
        if (resetDone) begin
            nChecks++;
            if (oGnt !== (sb.size() < DEPTH)) begin
                nFails++;
                $display("FAIL oGnt: got %b want %b (depth %0d)", oGnt, sb.size() < DEPTH, sb.size());
            end
            nChecks++;
            if (oReq !== (sb.size() != 0)) begin
                nFails++;
                $display("FAIL oReq: got %b want %b (depth %0d)", oReq, sb.size() != 0, sb.size());
            end
        end
        if (mPop) begin
            exp = sb.pop_front();
            nChecks++;
            if (oData !== exp) begin
                nFails++;
                $display("FAIL pop_data: got %h want %h", oData, exp);
            end
        end
        if (iRst || iFlush) begin
            sb.delete();
            mMax = 0;
        end else begin
            if (mPush) sb.push_back(iData);
            if (sb.size() > mMax) mMax = sb.size();
        end
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        iRst = 1'b0;
        sb.delete();
        mMax = 0;
        resetDone = 1'b1;
        #1;
        nChecks++;
        if (oReq !== 1'b0) begin nFails++; $display("FAIL reset_oReq: got %b want 0", oReq); end
        nChecks++;
        if (oGnt !== 1'b1) begin nFails++; $display("FAIL reset_oGnt: got %b want 1", oGnt); end
        nChecks++;
        if (oCount !== 3'd0) begin nFails++; $display("FAIL reset_oCount: got %0d want 0", oCount); end
        nChecks++;
        if (oAlmostFull !== 1'b0) begin nFails++; $display("FAIL reset_oAlmostFull: got %b want 0", oAlmostFull); end
        nChecks++;
        if (oMaxCount !== 3'd0) begin nFails++; $display("FAIL reset_oMaxCount: got %0d want 0", oMaxCount); end
    endtask

    task automatic test_fill();
        logic [7:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pat[i], 1'b0, 1'b0);
            step();
            nChecks++;
            if (oCount !== 3'(i + 1)) begin
                nFails++; $display("FAIL fill_oCount: got %0d want %0d", oCount, i + 1);
            end
            nChecks++;
            if (oAlmostFull !== (i + 1 >= AFULL_TH)) begin
                nFails++; $display("FAIL fill_oAlmostFull: got %b want %b after push %0d", oAlmostFull, i + 1 >= AFULL_TH, i + 1);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        nChecks++;
        if (oGnt !== 1'b0) begin nFails++; $display("FAIL fill_full_oGnt: got %b want 0", oGnt); end
        nChecks++;
        if (oData !== 8'h11) begin nFails++; $display("FAIL fill_head: got %h want 11", oData); end
    endtask

    task automatic test_full_block();
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        step();
        nChecks++;
        if (oCount !== 3'd3) begin nFails++; $display("FAIL block_oCount: got %0d want 3", oCount); end
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        step();
        nChecks++;
        if (oCount !== 3'd4) begin nFails++; $display("FAIL block_accept_oCount: got %0d want 4", oCount); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            step();
        end
        nChecks++;
        if (oReq !== 1'b0) begin nFails++; $display("FAIL block_drained_oReq: got %b want 0", oReq); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
            step();
            nChecks++;
            if (oCount !== 3'd1) begin nFails++; $display("FAIL stream_oCount: got %0d want 1 at cycle %0d", oCount, i); end
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        nChecks++;
        if (sb.size() != 0 || oReq !== 1'b0) begin
            nFails++; $display("FAIL stream_drain: got oReq %b left %0d want 0 0", oReq, sb.size());
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h99, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        nChecks++;
        if (oReq !== 1'b0) begin nFails++; $display("FAIL flush_oReq: got %b want 0", oReq); end
        nChecks++;
        if (oCount !== 3'd0) begin nFails++; $display("FAIL flush_oCount: got %0d want 0", oCount); end
        nChecks++;
        if (oMaxCount !== 3'd0) begin nFails++; $display("FAIL flush_oMaxCount: got %0d want 0", oMaxCount); end
        nChecks++;
        if (oAlmostFull !== 1'b0) begin nFails++; $display("FAIL flush_oAlmostFull: got %b want 0", oAlmostFull); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1'b1, 8'(r * 16 + i + 1), 1'b0, 1'b0);
                step();
            end
            nChecks++;
            if (oCount !== 3'd3) begin nFails++; $display("FAIL wrap_oCount: got %0d want 3 round %0d", oCount, r); end
            for (int i = 0; i < 3; i++) begin
                drive(1'b0, 8'h00, 1'b1, 1'b0);
                step();
            end
        end
        nChecks++;
        if (oMaxCount !== 3'(mMax) || mMax != 3) begin
            nFails++; $display("FAIL wrap_oMaxCount: got %0d want 3", oMaxCount);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'hC1, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hC2, 1'b0, 1'b0);
        step();
        iRst = 1'b1;
        drive(1'b1, 8'hC3, 1'b1, 1'b0);
        step();
        iRst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        nChecks++;
        if (oReq !== 1'b0) begin nFails++; $display("FAIL rstmid_oReq: got %b want 0", oReq); end
        nChecks++;
        if (oGnt !== 1'b1) begin nFails++; $display("FAIL rstmid_oGnt: got %b want 1", oGnt); end
        nChecks++;
        if (oCount !== 3'd0) begin nFails++; $display("FAIL rstmid_oCount: got %0d want 0", oCount); end
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        nChecks++;
        if (oReq !== 1'b1 || oData !== 8'hA5) begin
            nFails++; $display("FAIL rstmid_push: got oReq %b oData %h want 1 a5", oReq, oData);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        iRst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge iClk);
        test_reset();
        test_fill();
        test_full_block();
        test_stream();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
